// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer for the sequential Y86-64 core: owns the PC, walks the stages, handshakes data memory.
// Optional SINGLE_STEP_EN adds a step input and parks in IDLE after every committed instruction.
module pc_sequencer #(
  parameter int                ADDR_W      = 64,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic [3:0]        icode,
  input  logic              cnd,
  input  logic [ADDR_W-1:0] valC,
  input  logic [ADDR_W-1:0] valP,
  input  logic [ADDR_W-1:0] valM,
  input  logic              instr_valid,
  input  logic              imem_error,
  input  logic              dmem_error,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        stage,
  output logic [2:0]        stat,
  output logic              retire
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
  } state_t;

  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc_nx;
  logic [2:0]        stat_nx;
  logic              req_nx;
  logic [7:0]        cnt, cnt_nx;
  logic              mem_op, resume, to_fetch_after_pcupd;

  assign mem_op = icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
`ifdef SINGLE_STEP_EN
  assign resume               = start | step;
  assign to_fetch_after_pcupd = 1'b0;
`else
  assign resume               = start;
  assign to_fetch_after_pcupd = 1'b1;
`endif

  assign stage = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      stat    <= AOK;
      mem_req <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      stat    <= stat_nx;
      mem_req <= req_nx;
      cnt     <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    stat_nx  = stat;
    req_nx   = mem_req;
    cnt_nx   = cnt;
    retire   = 1'b0;
    case (state)
      S_IDLE:    if (resume) state_nx = S_FETCH;
      S_FETCH: begin
        if (imem_error) begin
          stat_nx = ADR; state_nx = S_HALT;
        end else if (!instr_valid) begin
          stat_nx = INS; state_nx = S_HALT;
        end else if (icode == 4'h0) begin
          stat_nx = HLT; state_nx = S_HALT;
        end else begin
          state_nx = S_DECODE;
        end
      end
      S_DECODE:  state_nx = S_EXECUTE;
      S_EXECUTE: begin
        state_nx = S_MEMORY;
        cnt_nx   = '0;
        req_nx   = 1'b0;
      end
      S_MEMORY: begin
        // First MEMORY cycle only raises the request; ack/timeout are judged while it is high
        if (!mem_op) begin
          state_nx = S_WRITEBACK;
        end else if (!mem_req) begin
          req_nx = 1'b1;
        end else if (mem_ack) begin
          req_nx = 1'b0;
          if (dmem_error) begin
            stat_nx = ADR; state_nx = S_HALT;
          end else begin
            state_nx = S_WRITEBACK;
          end
        end else begin
          cnt_nx = cnt + 8'd1;
          if (cnt == TMO_LAST) begin
            req_nx   = 1'b0;
            stat_nx  = ADR;
            state_nx = S_HALT;
          end
        end
      end
      S_WRITEBACK: state_nx = S_PCUPD;
      S_PCUPD: begin
        retire = 1'b1;
        case (icode)
          4'h7:    pc_nx = cnd ? valC : valP;
          4'h8:    pc_nx = valC;
          4'h9:    pc_nx = valM;
          default: pc_nx = valP;
        endcase
        state_nx = to_fetch_after_pcupd ? S_FETCH : S_IDLE;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_HALT;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against an instruction-level reference model.
module tb_pc_sequencer;
  localparam int          ADDR_W = 64;
  localparam logic [63:0] RST_PC = 64'h0;
  localparam int          TMO    = 15;

  logic              clk = 0, rst_n = 1, start = 0;
  logic [3:0]        icode = 0;
  logic              cnd = 0, instr_valid = 1, imem_error = 0, dmem_error = 0, mem_ack = 0;
  logic [ADDR_W-1:0] valC = 0, valP = 0, valM = 0;
  logic              mem_req, retire;
  logic [ADDR_W-1:0] pc;
  logic [2:0]        stage, stat;
`ifdef SINGLE_STEP_EN
  logic              step = 0;
`endif

  int n_chk = 0, n_pass = 0;
  logic [63:0] exp_pc;
  bit exp_halted;

  pc_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(RST_PC), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .icode(icode), .cnd(cnd), .valC(valC), .valP(valP), .valM(valM),
    .instr_valid(instr_valid), .imem_error(imem_error), .dmem_error(dmem_error),
    .mem_ack(mem_ack), .mem_req(mem_req), .pc(pc), .stage(stage), .stat(stat),
    .retire(retire)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit uses_mem(input logic [3:0] ic);
    return ic == 4'h4 || ic == 4'h5 || ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB;
  endfunction

  task automatic do_reset();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    exp_pc = RST_PC;
    exp_halted = 0;
    chk("rst_stage", 64'(stage), 64'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_stat", 64'(stat), 64'd1);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_retire", 64'(retire), 64'd0);
  endtask

  task automatic go();
    start = 1;
    @(negedge clk);
    start = 0;
    chk("go_fetch", 64'(stage), 64'd1);
  endtask

  // Runs one instruction from a FETCH negedge. wt = ack delay in request-high cycles; <0 means never ack.
  task automatic run_instr(input logic [3:0] ic, input logic iv, input logic ie, input logic cn,
                           input logic [63:0] vc, input logic [63:0] vp, input logic [63:0] vm,
                           input int wt, input logic de);
    int cyc, nret, nreq, seen, e_cyc, e_req, e_ret, e_stage, e_stat;
    bit mop;
    logic [63:0] e_pc;
    icode = ic; instr_valid = iv; imem_error = ie; cnd = cn;
    valC = vc; valP = vp; valM = vm; dmem_error = de;
    mop = uses_mem(ic);
    e_pc = exp_pc; e_ret = 0; e_req = 0; e_stage = 7; e_stat = 1;
    if (ie)              begin e_cyc = 1; e_stat = 3; end
    else if (!iv)        begin e_cyc = 1; e_stat = 4; end
    else if (ic == 4'h0) begin e_cyc = 1; e_stat = 2; end
    else if (mop && (wt < 0 || wt >= TMO)) begin e_cyc = 4 + TMO; e_req = TMO; e_stat = 3; end
    else if (mop && de)  begin e_cyc = 5 + wt; e_req = wt + 1; e_stat = 3; end
    else begin
      e_cyc = mop ? 7 + wt : 6;
      e_req = mop ? wt + 1 : 0;
      e_ret = 1;
`ifdef SINGLE_STEP_EN
      e_stage = 0;
`else
      e_stage = 1;
`endif
      case (ic)
        4'h7:    e_pc = cn ? vc : vp;
        4'h8:    e_pc = vc;
        4'h9:    e_pc = vm;
        default: e_pc = vp;
      endcase
    end
    cyc = 0; nret = 0; nreq = 0; seen = 0;
    do begin
      if (mop) begin
        mem_ack = mem_req && (seen == wt);
        if (mem_req) seen++;
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
      if (retire) nret++;
      if (mem_req) nreq++;
    end while (!(stage inside {3'd0, 3'd1, 3'd7}) && cyc < 200);
    mem_ack = 0; dmem_error = 0;
    chk("latency", 64'(cyc), 64'(e_cyc));
    chk("end_stage", 64'(stage), 64'(e_stage));
    chk("stat", 64'(stat), 64'(e_stat));
    chk("pc", pc, e_pc);
    chk("retire_cnt", 64'(nret), 64'(e_ret));
    chk("req_cycles", 64'(nreq), 64'(e_req));
    exp_pc = e_pc;
    exp_halted = (e_stage == 7);
`ifdef SINGLE_STEP_EN
    if (!exp_halted) begin
      @(negedge clk);
      chk("step_hold_idle", 64'(stage), 64'd0);
      step = 1;
      @(negedge clk);
      step = 0;
      chk("step_fetch", 64'(stage), 64'd1);
    end
`endif
  endtask

  // HALT must absorb start; only reset brings the core back.
  task automatic recover(input logic [2:0] code);
    start = 1;
    repeat (3) @(negedge clk);
    start = 0;
    chk("halt_absorb", 64'(stage), 64'd7);
    chk("halt_stat", 64'(stat), 64'(code));
    chk("halt_noreq", 64'(mem_req), 64'd0);
    do_reset();
    go();
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    go();
    run_instr(4'h6, 1, 0, 0, 64'h0, 64'h0A, 64'h0, 0, 0);
    run_instr(4'h7, 1, 0, 1, 64'h40, 64'h09, 64'h0, 0, 0);
    run_instr(4'h7, 1, 0, 0, 64'h40, 64'h09, 64'h0, 0, 0);
    run_instr(4'h9, 1, 0, 0, 64'h0, 64'h0, 64'h123, 3, 0);
    run_instr(4'h5, 1, 0, 0, 64'h0, 64'h77, 64'h0, 14, 0);
    run_instr(4'h0, 1, 0, 0, 64'h0, 64'h55, 64'h0, 0, 0);
    recover(3'd2);
    run_instr(4'h6, 0, 1, 0, 64'h0, 64'h55, 64'h0, 0, 0);
    recover(3'd3);
    run_instr(4'h5, 1, 0, 0, 64'h0, 64'h30, 64'h0, -1, 0);
    recover(3'd3);
    run_instr(4'hA, 1, 0, 0, 64'h0, 64'h30, 64'h0, 2, 1);
    recover(3'd3);

    // Reset while MEMORY has a request outstanding
    run_instr(4'h6, 1, 0, 0, 64'h0, 64'hBEEF, 64'h0, 0, 0);
    icode = 4'h4; valP = 64'h99;
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    chk("mid_req_high", 64'(mem_req), 64'd1);
    do_reset();
    go();

    for (int n = 0; n < 60; n++) begin
      logic [3:0] ic;
      logic iv, ie, de;
      int wt, r;
      r  = $urandom_range(0, 99);
      ic = 4'($urandom_range(1, 11));
      iv = 1; ie = 0; de = 0;
      wt = $urandom_range(0, 5);
      if (r < 4) ie = 1;
      else if (r < 8) iv = 0;
      else if (r < 11) ic = 4'h0;
      else if (r < 15) wt = -1;
      else if (r < 20) de = 1;
      run_instr(ic, iv, ie, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                {$urandom, $urandom}, {$urandom, $urandom}, wt, de);
      if (exp_halted) recover(stat);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle controller for the sequential Y86-64 core.
- Owns the architectural PC register and steps the core through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD, one stage per cycle.
- Selects and commits the next PC, handshakes with data memory, and raises processor status (AOK/HLT/ADR/INS), parking in HALT on any non-AOK condition.

Parameters:
- ADDR_W, 64, width of PC, valC, valP, valM.
- RESET_PC, 0, PC value loaded on reset.
- MEM_TIMEOUT, 15, max cycles waiting for mem_ack before an ADR fault (1..255).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin execution from IDLE.
- icode  in  4  instruction code from fetch logic.
- cnd  in  1  condition result from execute.
- valC  in  ADDR_W  immediate/destination from fetch.
- valP  in  ADDR_W  fall-through address from fetch.
- valM  in  ADDR_W  value read from data memory.
- instr_valid  in  1  fetch decoded a legal instruction.
- imem_error  in  1  fetch address out of range.
- dmem_error  in  1  data memory address fault, sampled with mem_ack.
- mem_ack  in  1  data memory transfer complete.
- mem_req  out  1  data memory request.
- pc  out  ADDR_W  current architectural PC.
- stage  out  3  IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, PCUPD=6, HALT=7.
- stat  out  3  AOK=1, HLT=2, ADR=3, INS=4.
- retire  out  1  one-cycle pulse when an instruction commits.

Behaviour:
- Reset (rst_n=0 at posedge): stage=IDLE, pc=RESET_PC, stat=AOK, mem_req=0, retire=0, timeout counter=0. Applies mid-instruction; any in-flight request is dropped.
- IDLE -> FETCH when start=1. Otherwise hold.
- FETCH: fault checks, in priority order:
  - imem_error=1 -> stat=ADR, go to HALT.
  - else instr_valid=0 -> stat=INS, go to HALT.
  - else icode=0 (halt) -> stat=HLT, go to HALT.
  - else go to DECODE.
  - On any fault, pc is unchanged and retire is not pulsed.
- DECODE -> EXECUTE -> MEMORY unconditionally, one cycle each.
- MEMORY, memory-using icodes (4 rmmovq, 5 mrmovq, 8 call, 9 ret, A pushq, B popq):
  - mem_req is registered: it goes high the cycle after MEMORY is entered and holds until the ack cycle.
  - mem_ack=1 with dmem_error=1 -> stat=ADR, go to HALT.
  - mem_ack=1 with dmem_error=0 -> go to WRITEBACK.
  - Counter increments each waiting cycle. On reaching MEM_TIMEOUT without ack: stat=ADR, go to HALT, mem_req=0.
  - mem_ack and timeout in the same cycle: ack wins.
- MEMORY, other icodes: mem_req stays 0; next cycle go to WRITEBACK. mem_ack is ignored.
- WRITEBACK -> PCUPD.
- PCUPD: next PC by icode:
  - 7 (jXX): valC if cnd=1, else valP.
  - 8 (call): valC.
  - 9 (ret): valM.
  - all others: valP.
  - pc loads the new value at this edge; retire=1 for this cycle only; go to FETCH.
- Next-PC arithmetic is pure selection with no increment; wraps naturally at 2^ADDR_W. Inputs must be stable during PCUPD.
- Latency: 6 cycles per instruction without memory. With memory, 7 + (ack wait cycles), where ack wait = cycles after mem_req rises before mem_ack.
- HALT is absorbing until reset. start is ignored there and while running. stat holds the fault code.

Optional Feature:
- SINGLE_STEP_EN: adds input port step (1 bit).
  - After PCUPD the FSM goes to IDLE instead of FETCH, keeping the new pc.
  - From IDLE, start or step (either) resumes at FETCH.
- Without the macro: port absent; PCUPD always goes to FETCH.

Test Plan:
- Reset, start, icode=6, valP=0x0A -> stage steps 1..6; retire pulses once; pc=0x0A at cycle 6 after FETCH; mem_req never asserted.
- icode=7, valC=0x40, valP=0x09: first with cnd=1 -> pc=0x40; then with cnd=0 -> pc=0x09.
- icode=9, valM=0x123, mem_ack 3 cycles after mem_req rises -> mem_req high exactly 4 cycles (3 wait + ack cycle); pc=0x123; 10 cycles FETCH to next FETCH.
- icode=5, no mem_ack, MEM_TIMEOUT=15 -> stat=ADR and stage=HALT after 15 waiting cycles; mem_req drops; start ignored afterwards.
- At FETCH: icode=0 -> stat=HLT, pc unchanged, no retire. Separately, instr_valid=0 with imem_error=1 -> stat=ADR (priority over INS).
- rst_n=0 while stage=MEMORY with mem_req high -> next cycle stage=IDLE, pc=RESET_PC, stat=AOK, mem_req=0. With SINGLE_STEP_EN, a step pulse executes exactly one instruction, then returns to IDLE.
